seg_scan_driver: RTL and testbench
==================================

// Module: seg_scan_driver
// PURPOSE
//  Producer side of the 7-segment path. Takes a binary sample (e.g. a 10-bit ADC code),
//  converts it to BCD with a sequential shift-add-3 engine, and time-multiplexes the digits.
//  Each scan slot it presents one BCD digit plus its enable to the hex/segment decoder.
//  It also drives the active-low digit-select lines of a common-anode multi-digit display.
// PARAMETERS
//  NUM_DIGITS  4      number of display digits (2..8)
//  DATA_W      10     width of binary input value (1..26)
//  SCAN_DIV    50000  clk cycles per digit slot (>=2)
// PORTS
//  clk        in   1              system clock, all logic on rising edge
//  rst_n      in   1              asynchronous active-low reset
//  load       in   1              1-cycle strobe: capture value and start conversion
//  value      in   DATA_W         unsigned binary value to display
//  busy       out  1              conversion in progress; load ignored while high
//  digit_bcd  out  4              BCD digit of current slot -> decoder 'in'
//  digit_en   out  1              digit enable -> decoder 'en' (0 = blank)
//  digit_sel  out  NUM_DIGITS     active-low digit select, one-cold; bit 0 = least-significant digit
// BEHAVIOUR
//  Reset (async, rst_n=0): busy=0, digit_bcd=0, digit_en=0, digit_sel=all 1s.
//   Also cleared: display register=0, scan counter=0, digit index=0, FSM=IDLE.
//  FSM: IDLE -> CONV -> COMMIT -> IDLE.
//   IDLE: load=1 captures value into shift reg, clears BCD accumulator, iter=0 -> CONV.
//   CONV: one bit/cycle; per cycle add 3 to each BCD nibble >=5, then shift left 1.
//    After DATA_W iterations -> COMMIT.
//   COMMIT: if result > 10^NUM_DIGITS-1, display register = all 9s (saturate);
//    else display register = BCD result. -> IDLE.
//  busy=1 in CONV and COMMIT. Latency: load to updated display = DATA_W+2 cycles.
//  load while busy: ignored, no queueing. load coincident with COMMIT: ignored.
//  Display register updates atomically in COMMIT only; scan never shows partial results.
//  Scan: counter runs 0..SCAN_DIV-1 continuously from reset, independent of the FSM.
//   At terminal count: counter->0, digit index +1, wraps NUM_DIGITS-1 -> 0.
//  Outputs registered, updated on the cycle the index changes:
//   digit_sel = ~(1<<index); digit_bcd = display nibble[index].
//   Outside reset exactly one digit_sel bit is low.
//  digit_en=1 for all slots unless blanking (CONFIGURATION) applies.
//  Reset mid-conversion: conversion aborted; display returns to 0 on release.
// CONFIGURATION
//  Macro LEADING_ZERO_BLANK_EN:
//   defined: digit_en=0 for every zero nibble above the most significant nonzero digit.
//    Digit 0 is never blanked, so value 0 shows a single "0".
//   undefined: digit_en=1 in every slot; all digits shown including leading zeros.
//  digit_sel scanning is identical in both builds.
// TESTING
//  T1 reset: rst_n=0 mid-scan -> busy=0, digit_en=0, digit_sel=4'b1111 immediately (async).
//  T2 convert: load with value=10'd1023 -> busy high 11 cycles.
//   Then slots 0..3 show bcd 3,2,0,1, digit_sel 1110,1101,1011,0111 every SCAN_DIV cycles.
//  T3 ignored load: load value=5, then load value=999 while busy -> display shows 0005.
//   Second load has no effect; busy deasserts DATA_W+2 cycles after the first load.
//  T4 wrap/boundaries: value=0 and value=9 with SCAN_DIV=4.
//   Index wraps 3->0 every 16 cycles; digit 0 shows 0 and 9 respectively.
//  T5 blanking: LEADING_ZERO_BLANK_EN defined, value=42.
//   digit_en=1 for slots 0,1; 0 for slots 2,3. Macro undefined: all slots en=1, showing 0042.
//  T6 saturation: NUM_DIGITS=2, DATA_W=10, value=150 -> both digits show 9.

Source files
------------

// File: rtl/seg_scan_driver.sv
// Binary-to-BCD converter (sequential shift-add-3) with a time-multiplexed common-anode digit scanner.
// Optional build macro LEADING_ZERO_BLANK_EN blanks zero digits above the most significant nonzero digit.
module seg_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int DATA_W     = 10,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_W-1:0]     value,
  output logic                  busy,
  output logic [3:0]            digit_bcd,
  output logic                  digit_en,
  output logic [NUM_DIGITS-1:0] digit_sel
);

  localparam int ACC_W  = 32;
  localparam int DISP_W = 4 * NUM_DIGITS;
  localparam int CNT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W  = $clog2(NUM_DIGITS);
  localparam int ITER_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_COMMIT} state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_shift;
  logic [ACC_W-1:0]    r_acc;
  logic [ITER_W-1:0]   r_iter;
  logic [DISP_W-1:0]   r_disp;
  logic                r_busy;
  logic [CNT_W-1:0]    r_cnt;
  logic [IDX_W-1:0]    r_idx;
  logic [3:0]          r_bcd;
  logic                r_en;
  logic [NUM_DIGITS-1:0] r_sel;

  logic [ACC_W-1:0]    w_adj;
  logic [ACC_W-1:0]    w_acc_nxt;
  logic                w_ovf;
  logic                w_tc;
  logic [IDX_W-1:0]    w_idx_nxt;
  logic                w_blank;

  // Eight BCD nibbles always suffice: 2^26-1 has eight decimal digits.
  always_comb begin
    w_adj = r_acc;
    for (int i = 0; i < 8; i++) begin
      if (r_acc[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_acc[4*i +: 4] + 4'd3;
    end
    w_acc_nxt = {w_adj[ACC_W-2:0], r_shift[DATA_W-1]};
  end

  always_comb begin
    w_ovf = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i >= NUM_DIGITS && r_acc[4*i +: 4] != 4'd0) w_ovf = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_acc   <= '0;
      r_iter  <= '0;
      r_disp  <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (load) begin
            r_shift <= value;
            r_acc   <= '0;
            r_iter  <= '0;
            r_busy  <= 1'b1;
            r_state <= S_CONV;
          end
        end
        S_CONV: begin
          r_acc   <= w_acc_nxt;
          r_shift <= r_shift << 1;
          r_iter  <= r_iter + 1'b1;
          if (r_iter == ITER_W'(DATA_W - 1)) r_state <= S_COMMIT;
        end
        S_COMMIT: begin
          r_disp  <= w_ovf ? {NUM_DIGITS{4'h9}} : r_acc[DISP_W-1:0];
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign w_tc      = (r_cnt == CNT_W'(SCAN_DIV - 1));
  assign w_idx_nxt = !w_tc ? r_idx :
                     (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;

`ifdef LEADING_ZERO_BLANK_EN
  logic w_upper_zero;
  // Walk down from the top digit; a slot is blank if it and everything above it are zero.
  always_comb begin
    w_blank      = 1'b0;
    w_upper_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      w_upper_zero = w_upper_zero & (r_disp[4*i +: 4] == 4'd0);
      if (i == int'(w_idx_nxt)) w_blank = w_upper_zero;
    end
  end
`else
  assign w_blank = 1'b0;
`endif

  // Outputs track the index being entered, so they change on the same edge as the index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
      r_bcd <= 4'd0;
      r_en  <= 1'b0;
      r_sel <= '1;
    end else begin
      r_cnt <= w_tc ? '0 : r_cnt + 1'b1;
      r_idx <= w_idx_nxt;
      r_bcd <= r_disp[4*w_idx_nxt +: 4];
      r_en  <= ~w_blank;
      r_sel <= ~(NUM_DIGITS'(1) << w_idx_nxt);
    end
  end

  assign busy      = r_busy;
  assign digit_bcd = r_bcd;
  assign digit_en  = r_en;
  assign digit_sel = r_sel;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: a 4-digit instance and a 2-digit instance (saturation), SCAN_DIV=4.
module tb_seg_scan_driver;

  localparam int DW = 10;
  localparam int SD = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load, load2;
  logic [9:0] value, value2;
  logic       busy, busy2;
  logic [3:0] bcd, bcd2;
  logic       en, en2;
  logic [3:0] sel;
  logic [1:0] sel2;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  seg_scan_driver #(.NUM_DIGITS(4), .DATA_W(DW), .SCAN_DIV(SD)) u_dut (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value), .busy(busy),
    .digit_bcd(bcd), .digit_en(en), .digit_sel(sel)
  );

  seg_scan_driver #(.NUM_DIGITS(2), .DATA_W(DW), .SCAN_DIV(SD)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .load(load2), .value(value2), .busy(busy2),
    .digit_bcd(bcd2), .digit_en(en2), .digit_sel(sel2)
  );

  typedef struct {
    logic [9:0]  v;
    logic [15:0] exp_bcd;
    logic [3:0]  blank_mask;
    logic        which;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic do_load(input logic which, input logic [9:0] v);
    @(posedge clk); #1;
    if (which) begin load2 = 1'b1; value2 = v; end
    else       begin load  = 1'b1; value  = v; end
    @(posedge clk); #1;
    load  = 1'b0;
    load2 = 1'b0;
  endtask

  // Counts negedge samples with busy high; optionally fires a second load on dut 0 mid-conversion.
  task automatic busy_len(input logic which, input int second_at, output int n);
    n = 0;
    @(negedge clk);
    while ((which ? busy2 : busy) && n < 60) begin
      n++;
      if (second_at != 0 && n == second_at) begin load = 1'b1; value = 10'd999; end
      else load = 1'b0;
      @(negedge clk);
    end
    load = 1'b0;
  endtask

  task automatic walk(input string tag, input logic which, input logic [15:0] exp_bcd,
                      input logic [3:0] mask);
    int         t;
    int         nd;
    int         kk;
    logic [3:0] one;
    logic [3:0] exp_sel;
    logic [3:0] act_sel;
    logic [3:0] exp_en;
`ifdef LEADING_ZERO_BLANK_EN
    exp_en = mask;
`else
    exp_en = 4'hF;
`endif
    nd  = which ? 2 : 4;
    one = 4'b0001;
    t   = 0;
    @(negedge clk);
    act_sel = which ? {2'b11, sel2} : sel;
    while (act_sel != 4'b1110 && t < 40) begin
      t++;
      @(negedge clk);
      act_sel = which ? {2'b11, sel2} : sel;
    end
    chk({tag, " slot0_found"}, act_sel, 4'b1110);
    for (int k = 0; k <= nd; k++) begin
      kk      = k % nd;
      exp_sel = ~(one << kk);
      act_sel = which ? {2'b11, sel2} : sel;
      chk($sformatf("%s sel[%0d]", tag, k), act_sel, exp_sel);
      chk($sformatf("%s bcd[%0d]", tag, k), which ? bcd2 : bcd, exp_bcd[4*kk +: 4]);
      chk($sformatf("%s en[%0d]", tag, k), which ? en2 : en, exp_en[kk]);
      repeat (SD) @(negedge clk);
    end
  endtask

  vec_t vecs[10];
  int   n;

  initial begin
    vecs[0] = '{10'd1023, 16'h1023, 4'hF, 1'b0};
    vecs[1] = '{10'd0,    16'h0000, 4'h1, 1'b0};
    vecs[2] = '{10'd9,    16'h0009, 4'h1, 1'b0};
    vecs[3] = '{10'd42,   16'h0042, 4'h3, 1'b0};
    vecs[4] = '{10'd1000, 16'h1000, 4'hF, 1'b0};
    vecs[5] = '{10'd100,  16'h0100, 4'h7, 1'b0};
    vecs[6] = '{10'd150,  16'h0099, 4'h3, 1'b1};
    vecs[7] = '{10'd100,  16'h0099, 4'h3, 1'b1};
    vecs[8] = '{10'd7,    16'h0007, 4'h1, 1'b1};
    vecs[9] = '{10'd99,   16'h0099, 4'h3, 1'b1};

    rst_n = 1'b0; load = 1'b0; load2 = 1'b0; value = '0; value2 = '0;
    repeat (3) @(negedge clk);
    chk("rst busy", busy, 1'b0);
    chk("rst en", en, 1'b0);
    chk("rst sel", sel, 4'b1111);
    chk("rst bcd", bcd, 4'd0);
    chk("rst sel2", sel2, 2'b11);
    rst_n = 1'b1;

    walk("post_reset", 1'b0, 16'h0000, 4'h1);

    foreach (vecs[i]) begin
      do_load(vecs[i].which, vecs[i].v);
      busy_len(vecs[i].which, 0, n);
      chk($sformatf("vec%0d busy_cycles", i), n, DW + 1);
      walk($sformatf("vec%0d", i), vecs[i].which, vecs[i].exp_bcd, vecs[i].blank_mask);
    end

    // Second load during conversion must be dropped.
    do_load(1'b0, 10'd5);
    busy_len(1'b0, 3, n);
    chk("ignored_load busy_cycles", n, DW + 1);
    walk("ignored_load", 1'b0, 16'h0005, 4'h1);

    // Asynchronous reset mid-scan and mid-conversion, applied away from a clock edge.
    do_load(1'b0, 10'd1023);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst busy", busy, 1'b0);
    chk("async_rst en", en, 1'b0);
    chk("async_rst sel", sel, 4'b1111);
    chk("async_rst bcd", bcd, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("abort busy", busy, 1'b0);
    walk("after_abort", 1'b0, 16'h0000, 4'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
